// File: rtl/seq_alu_pkg.sv
// Shared opcode map, FSM state encoding and error bit positions for seq_alu.
// Opcodes 12/13 (MAC/CLRACC) are only decoded when SEQ_ALU_ACCUM_EN is defined.
package seq_alu_pkg;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_MUL    = 4'd2;
  localparam logic [3:0] OP_DIV    = 4'd3;
  localparam logic [3:0] OP_MOD    = 4'd4;
  localparam logic [3:0] OP_XOR    = 4'd5;
  localparam logic [3:0] OP_XNOR   = 4'd6;
  localparam logic [3:0] OP_OR     = 4'd7;
  localparam logic [3:0] OP_NOR    = 4'd8;
  localparam logic [3:0] OP_AND    = 4'd9;
  localparam logic [3:0] OP_NAND   = 4'd10;
  localparam logic [3:0] OP_NOT    = 4'd11;
  localparam logic [3:0] OP_MAC    = 4'd12;
  localparam logic [3:0] OP_CLRACC = 4'd13;
  localparam logic [3:0] OP_PRESET = 4'd14;
  localparam logic [3:0] OP_CLEAR  = 4'd15;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int ERR_OVF  = 0;
  localparam int ERR_DIV0 = 1;

  function automatic logic is_mul_op(input logic [3:0] op);
`ifdef SEQ_ALU_ACCUM_EN
    return (op == OP_MUL) || (op == OP_MAC);
`else
    return (op == OP_MUL);
`endif
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Shared iterative datapath: shift-add multiply (mode=0) or restoring divide (mode=1).
// Outputs are the values produced by the current iteration, so done and the result coincide.
module seq_alu_muldiv #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder
);

  localparam int CW = $clog2(WIDTH);

  logic               run_reg;
  logic               mode_reg;
  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] opb_reg;
  logic [WIDTH-1:0]   opa_reg;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;
  logic               qbit;

  // Multiply: opa is the multiplier shifting right, opb the multiplicand shifting left.
  assign product = acc_reg + (opa_reg[0] ? opb_reg : '0);

  // Divide: acc holds the partial remainder, opa shifts dividend out and quotient in.
  assign trial     = {acc_reg[WIDTH-1:0], opa_reg[WIDTH-1]};
  assign diff      = trial - {1'b0, opb_reg[WIDTH-1:0]};
  assign qbit      = ~diff[WIDTH];
  assign remainder = qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quotient  = {opa_reg[WIDTH-2:0], qbit};

  assign done = run_reg && (cnt_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      run_reg  <= 1'b0;
      mode_reg <= 1'b0;
      cnt_reg  <= '0;
      acc_reg  <= '0;
      opa_reg  <= '0;
      opb_reg  <= '0;
    end else if (start) begin
      run_reg  <= 1'b1;
      mode_reg <= mode;
      cnt_reg  <= '0;
      acc_reg  <= '0;
      opa_reg  <= a;
      opb_reg  <= {{WIDTH{1'b0}}, b};
    end else if (run_reg) begin
      cnt_reg <= cnt_reg + CW'(1);
      run_reg <= !done;
      if (mode_reg) begin
        acc_reg <= {{WIDTH{1'b0}}, remainder};
        opa_reg <= quotient;
      end else begin
        acc_reg <= product;
        opa_reg <= opa_reg >> 1;
        opb_reg <= opb_reg << 1;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered opcode ALU with valid/ready handshake; MUL/DIV/MOD iterate over WIDTH cycles.
// Define SEQ_ALU_ACCUM_EN to add the MAC/CLRACC accumulator opcodes.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     input_a,
  input  logic [WIDTH-1:0]     input_b,
  input  logic [3:0]           opcode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic [1:0]           error,
  output logic                 busy
);

  logic [1:0]         state_reg;
  logic [3:0]         op_reg;
  logic [2*WIDTH-1:0] result_reg;
  logic [1:0]         error_reg;
  logic               accept;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] op_result;
  logic [1:0]         op_error;
  logic               md_start;
  logic               md_done;
  logic [2*WIDTH-1:0] md_product;
  logic [WIDTH-1:0]   md_quotient;
  logic [WIDTH-1:0]   md_remainder;
`ifdef SEQ_ALU_ACCUM_EN
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] mac_sum;
  assign mac_sum = acc_reg + md_product;
`endif

  assign in_ready  = (state_reg == ST_IDLE) && !reset;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_reg == ST_DONE);
  assign busy      = (state_reg == ST_MUL) || (state_reg == ST_DIV);
  assign result    = result_reg;
  assign error     = error_reg;

  assign sum  = {1'b0, input_a} + {1'b0, input_b};
  assign diff = {1'b0, input_a} - {1'b0, input_b};

  always_comb begin
    op_result = '0;
    op_error  = '0;
    case (opcode)
      OP_ADD: begin
        op_result = {{(WIDTH-1){1'b0}}, sum};
        op_error[ERR_OVF] = sum[WIDTH] ^ (input_a[WIDTH-1] ^ input_b[WIDTH-1] ^ sum[WIDTH-1]);
      end
      OP_SUB: begin
        // Subtraction as A + ~B + 1: carry out is the inverted borrow.
        op_result = {{WIDTH{diff[WIDTH]}}, diff[WIDTH-1:0]};
        op_error[ERR_OVF] = ~diff[WIDTH] ^ (input_a[WIDTH-1] ^ ~input_b[WIDTH-1] ^ diff[WIDTH-1]);
      end
      OP_DIV, OP_MOD: op_error[ERR_DIV0] = (input_b == '0);
      OP_XOR:    op_result = {{WIDTH{1'b0}}, input_a ^ input_b};
      OP_XNOR:   op_result = {{WIDTH{1'b0}}, ~(input_a ^ input_b)};
      OP_OR:     op_result = {{WIDTH{1'b0}}, input_a | input_b};
      OP_NOR:    op_result = {{WIDTH{1'b0}}, ~(input_a | input_b)};
      OP_AND:    op_result = {{WIDTH{1'b0}}, input_a & input_b};
      OP_NAND:   op_result = {{WIDTH{1'b0}}, ~(input_a & input_b)};
      OP_NOT:    op_result = {{WIDTH{1'b0}}, ~input_a};
      OP_PRESET: op_result = '1;
      default:   op_result = '0;
    endcase
  end

  assign md_start = accept && (is_mul_op(opcode) || (is_div_op(opcode) && (input_b != '0)));

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .reset     (reset),
    .start     (md_start),
    .mode      (is_div_op(opcode)),
    .a         (input_a),
    .b         (input_b),
    .done      (md_done),
    .product   (md_product),
    .quotient  (md_quotient),
    .remainder (md_remainder)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      op_reg     <= '0;
      result_reg <= '0;
      error_reg  <= '0;
`ifdef SEQ_ALU_ACCUM_EN
      acc_reg    <= '0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            op_reg <= opcode;
            if (is_mul_op(opcode)) begin
              state_reg <= ST_MUL;
            end else if (is_div_op(opcode) && (input_b != '0)) begin
              state_reg <= ST_DIV;
            end else begin
              state_reg  <= ST_DONE;
              result_reg <= op_result;
              error_reg  <= op_error;
`ifdef SEQ_ALU_ACCUM_EN
              if (opcode == OP_CLRACC) acc_reg <= '0;
`endif
            end
          end
        end
        ST_MUL: begin
          if (md_done) begin
            state_reg <= ST_DONE;
            error_reg <= '0;
`ifdef SEQ_ALU_ACCUM_EN
            if (op_reg == OP_MAC) begin
              acc_reg    <= mac_sum;
              result_reg <= mac_sum;
            end else begin
              result_reg <= md_product;
            end
`else
            result_reg <= md_product;
`endif
          end
        end
        ST_DIV: begin
          if (md_done) begin
            state_reg  <= ST_DONE;
            error_reg  <= '0;
            result_reg <= {{WIDTH{1'b0}}, (op_reg == OP_MOD) ? md_remainder : md_quotient};
          end
        end
        default: begin
          if (out_ready) state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Randomized self-checking bench for seq_alu against an arithmetic reference model.
// Honours SEQ_ALU_ACCUM_EN the same way as the design.
module tb_seq_alu;

  localparam int W  = 16;
  localparam int BW = 2 * W;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  input_a;
  logic [W-1:0]  input_b;
  logic [3:0]    opcode;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] result;
  logic [1:0]    error;
  logic          busy;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .input_a   (input_a),
    .input_b   (input_b),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .error     (error),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [BW-1:0] res;
    logic [1:0]    err;
    int            lat;
    longint        acc_cyc;
    bit            lit_en;
    logic [BW-1:0] lit_res;
    logic [1:0]    lit_err;
  } exp_t;

  exp_t          q[$];
  longint        cyc = 0;
  int            n_vec = 0;
  int            n_err = 0;
  bit            mon_en = 0;
  logic [BW-1:0] model_acc = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [BW-1:0] res, output logic [1:0] err, output int lat);
    longint ua, ub, sa, sb, s, lim;
    logic [W-1:0] t;
    ua  = longint'(a);
    ub  = longint'(b);
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lim = longint'(1) << (W - 1);
    res = '0;
    err = 2'b00;
    lat = 1;
    case (op)
      4'd0: begin s = ua + ub; res = s[BW-1:0]; s = sa + sb; err[0] = (s >= lim) || (s < -lim); end
      4'd1: begin s = ua - ub; res = s[BW-1:0]; s = sa - sb; err[0] = (s >= lim) || (s < -lim); end
      4'd2: begin s = ua * ub; res = s[BW-1:0]; lat = W + 1; end
      4'd3, 4'd4: begin
        if (ub == 0) err = 2'b10;
        else begin
          s = (op == 4'd3) ? ua / ub : ua % ub;
          res = s[BW-1:0];
          lat = W + 1;
        end
      end
      4'd5:  begin t = a ^ b;    res = BW'(t); end
      4'd6:  begin t = ~(a ^ b); res = BW'(t); end
      4'd7:  begin t = a | b;    res = BW'(t); end
      4'd8:  begin t = ~(a | b); res = BW'(t); end
      4'd9:  begin t = a & b;    res = BW'(t); end
      4'd10: begin t = ~(a & b); res = BW'(t); end
      4'd11: begin t = ~a;       res = BW'(t); end
`ifdef SEQ_ALU_ACCUM_EN
      4'd12: begin s = ua * ub; model_acc = model_acc + s[BW-1:0]; res = model_acc; lat = W + 1; end
      4'd13: begin model_acc = '0; res = '0; end
`endif
      4'd14: res = '1;
      default: res = '0;
    endcase
  endfunction

  // Compare process: every cycle, outputs must match the timing and values of the queue head.
  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() == 0) begin
        chk("idle_out_valid", 64'(out_valid), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
      end else begin
        exp_t   e;
        longint elapsed;
        bit     exp_v;
        e = q[0];
        elapsed = cyc - e.acc_cyc + 1;
        exp_v = (elapsed >= e.lat);
        chk("out_valid", 64'(out_valid), 64'(exp_v));
        chk("busy", 64'(busy), 64'((e.lat > 1) && (elapsed < e.lat)));
        if (out_valid && exp_v) begin
          chk("result", 64'(result), 64'(e.res));
          chk("error", 64'(error), 64'(e.err));
          if (e.lit_en) begin
            chk("literal_result", 64'(result), 64'(e.lit_res));
            chk("literal_error", 64'(error), 64'(e.lit_err));
          end
          if (out_ready) begin
            $display("txn op=%0d a=%h b=%h result=%h error=%b latency=%0d",
                     e.op, e.a, e.b, result, error, elapsed);
            void'(q.pop_front());
          end
        end
      end
    end
  end

  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int hold, input bit lit_en, input logic [BW-1:0] lit_res,
                       input logic [1:0] lit_err);
    exp_t e;
    bit   seen;
    @(negedge clk);
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    input_a  = a;
    input_b  = b;
    opcode   = op;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    e.op = op; e.a = a; e.b = b;
    model(op, a, b, e.res, e.err, e.lat);
    e.acc_cyc = cyc;
    e.lit_en = lit_en; e.lit_res = lit_res; e.lit_err = lit_err;
    q.push_back(e);
    // Scramble inputs after accept: the captured operands must be used.
    in_valid  = 1'b0;
    input_a   = W'($urandom);
    input_b   = W'($urandom);
    opcode    = 4'($urandom);
    out_ready = (hold == 0);
    if (hold > 0) begin
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        seen = out_valid;
      end
      if (!seen) timeout("wait_out_valid");
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("in_ready_done", 64'(in_ready), 64'd0);
        in_valid = 1'($urandom);
        opcode   = 4'($urandom);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = (q.size() == 0);
    end
    if (!seen) begin
      timeout("wait_transfer");
      q.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]   op;
    logic [W-1:0] a, b;
    int           hold;
    reset     = 1'b1;
    in_valid  = 1'b0;
    input_a   = '0;
    input_b   = '0;
    opcode    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_error", 64'(error), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    mon_en = 1;

    do_op(4'd0,  16'h000F, 16'h007E, 0, 1, 32'h0000008D, 2'b00);
    do_op(4'd1,  16'h000F, 16'h007E, 0, 1, 32'hFFFFFF91, 2'b00);
    do_op(4'd2,  16'hF3FF, 16'h647E, 0, 1, 32'h5FC7B382, 2'b00);
    do_op(4'd0,  16'h7FFF, 16'h0001, 0, 1, 32'h00008000, 2'b01);
    do_op(4'd3,  16'hF3FF, 16'h647E, 0, 1, 32'h00000002, 2'b00);
    do_op(4'd4,  16'hF3FF, 16'h647E, 0, 1, 32'h00002B03, 2'b00);
    do_op(4'd3,  16'h1234, 16'h0000, 0, 1, 32'h00000000, 2'b10);
    do_op(4'd14, 16'h0000, 16'h0000, 0, 1, 32'hFFFFFFFF, 2'b00);
    do_op(4'd0,  16'h1234, 16'h4321, 5, 1, 32'h00005555, 2'b00);

    // Abort a multiply part-way through with reset.
    @(negedge clk);
    input_a  = 16'hABCD;
    input_b  = 16'h1357;
    opcode   = 4'd2;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    begin
      exp_t e;
      e.op = 4'd2; e.a = 16'hABCD; e.b = 16'h1357;
      model(e.op, e.a, e.b, e.res, e.err, e.lat);
      e.acc_cyc = cyc; e.lit_en = 0; e.lit_res = '0; e.lit_err = '0;
      q.push_back(e);
    end
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("in_ready_in_reset", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    model_acc = '0;
    @(negedge clk);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_error", 64'(error), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);

`ifdef SEQ_ALU_ACCUM_EN
    do_op(4'd12, 16'd3, 16'd4, 0, 1, 32'd12, 2'b00);
    do_op(4'd12, 16'd5, 16'd6, 0, 1, 32'd42, 2'b00);
    do_op(4'd13, 16'd0, 16'd0, 0, 1, 32'd0, 2'b00);
`endif

    for (int n = 0; n < 300; n++) begin
      op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0: a = 16'h7FFF;
        1: a = 16'hFFFF;
        default: a = W'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = 16'h8000;
        2: b = W'($urandom_range(1, 15));
        default: b = W'($urandom);
      endcase
      hold = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 4) : 0;
      do_op(op, a, b, hold, 0, '0, 2'b00);
    end

    mon_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the 16-bit combinational opcode ALU, with a valid/ready handshake on input and output.
- Single-cycle ops (add/sub/logic/constants) complete in 1 cycle.
- Multiply uses an iterative shift-add engine; divide and modulus use an iterative restoring divider. Both take WIDTH+1 cycles.
- Sits between the operand/opcode source and the result register file; keeps the existing 4-bit opcode map and 2-bit error encoding.

Parameters:
- WIDTH, 16, operand width in bits (>=2). Result width is 2*WIDTH.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- in_valid  input  1  operands/opcode valid
- in_ready  output  1  block can accept; high only in IDLE and not in reset
- input_a  input  WIDTH  operand A (unsigned)
- input_b  input  WIDTH  operand B (unsigned)
- opcode  input  4  operation select
- out_valid  output  1  result/error valid
- out_ready  input  1  consumer accepts result
- result  output  2*WIDTH  registered result
- error  output  2  [0] add/sub signed overflow; [1] divide/modulus by zero
- busy  output  1  high in MUL or DIV state

Behaviour:
- Opcode map:
  - 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD
  - 5 XOR, 6 XNOR, 7 OR, 8 NOR, 9 AND, 10 NAND, 11 NOT(A)
  - 12/13 reserved (see optional feature)
  - 14 PRESET (all ones), 15 CLEAR (zero)
- FSM states: IDLE, MUL, DIV, DONE.
- Accept happens on a rising edge where in_valid && in_ready. Operands and opcode are captured at accept; later input changes are ignored.
- IDLE transitions on accept:
  - MUL opcode -> MUL.
  - DIV/MOD with B!=0 -> DIV.
  - All other cases, including DIV/MOD with B==0 -> DONE. result and error are loaded on the same edge, so latency is 1 cycle.
- MUL: W iterations, one bit of A per cycle, shift-add into a 2W accumulator. After the last iteration -> DONE. Latency WIDTH+1 cycles from accept to out_valid.
- DIV: W restoring iterations, one quotient bit per cycle. After the last iteration -> DONE. result is the zero-extended quotient (DIV) or the zero-extended remainder (MOD). Latency WIDTH+1.
- DONE: out_valid=1. result and error stay stable until out_valid && out_ready, then -> IDLE. out_valid drops on that same edge. in_ready stays low in DONE, so there is no back-to-back accept.
- ADD: result[WIDTH:0] = A+B (carry in bit WIDTH); upper bits 0.
- SUB: result[WIDTH-1:0] = A-B; bits [2W-1:WIDTH] all equal the borrow (sign extension).
- error[0] = carry_out XOR carry_into_msb, for ADD/SUB only; otherwise 0.
- error[1] = 1 only for DIV/MOD with B==0; result is 0 in that case.
- Logic ops: WIDTH-bit result, zero-extended; error=00.
- PRESET: result = all ones (2*WIDTH bits). CLEAR: result = 0.
- Reset at any time (including mid-MUL/DIV or held in DONE):
  - Next state IDLE; the operation is aborted and not reported.
  - out_valid=0, result=0, error=00, busy=0.
  - Iteration counter and internal accumulators cleared.
- busy=1 exactly during MUL/DIV iterations.

Optional Feature:
- Macro: SEQ_ALU_ACCUM_EN.
- Defined:
  - Adds a 2*WIDTH accumulator register, reset to 0.
  - Opcode 12 MAC: multi-cycle multiply as for MUL, then acc <= acc + A*B (mod 2^(2W)); result = new acc; error=00; latency WIDTH+1.
  - Opcode 13 CLRACC: acc <= 0, result=0, latency 1.
- Not defined: opcodes 12/13 behave as single-cycle ops returning result=0, error=00, and no accumulator exists.

Decomposition:
- Package seq_alu_pkg holds:
  - opcode constants OP_ADD..OP_CLEAR, plus OP_MAC and OP_CLRACC;
  - state enum (IDLE/MUL/DIV/DONE);
  - error bit indices ERR_OVF=0, ERR_DIV0=1.
- One sub-module: seq_alu_muldiv, the shared iterative shift-add/restoring-divide datapath. Inputs are start/mode; it returns done plus a 2W product, quotient and remainder. Top level owns the FSM, handshake, single-cycle ops and output registers.

Test Plan (WIDTH=16):
- ADD A=0x000F B=0x007E, out_ready=1 -> after 1 cycle out_valid=1, result=0x0000008D, error=00; SUB with the same operands -> result=0xFFFFFF91, error=00.
- MUL A=0xF3FF B=0x647E -> busy=1 for 16 cycles, out_valid on cycle 17, result=0x5FC7B382, error=00; ADD 0x7FFF+0x0001 -> error=01.
- DIV A=0xF3FF B=0x647E -> result=0x00000002; MOD with the same operands -> result=0x00002B03; both with latency 17 and error=00.
- DIV with B=0x0000 -> after 1 cycle result=0, error=10, busy never asserted; PRESET -> result=0xFFFFFFFF.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE -> result/error stable, in_ready=0, in_valid pulses ignored; raise out_ready -> one transfer, then in_ready=1.
- Reset asserted on cycle 8 of a MUL -> next cycle out_valid=0, result=0, busy=0, in_ready=1 after reset drops; with SEQ_ALU_ACCUM_EN, MAC 3*4 then MAC 5*6 -> results 12 then 42.
